// File: rtl/store_pkg.sv
// -----------------------------------------------------------------------------
// store_pkg
//   Shared definitions for the load/store sub-word path.
//   - RISC-V funct3 codes for stores and for the matching loads.
//   - Encoding of the store read-modify-write FSM states.
//   - is_bad_store(): classifies a store request as undefined or misaligned.
// -----------------------------------------------------------------------------
package store_pkg;

    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Load funct3 codes, kept here so the load extend stage shares one source
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
    localparam logic [2:0] ST_READ_ENC  = 3'd1;
    localparam logic [2:0] ST_MERGE_ENC = 3'd2;
    localparam logic [2:0] ST_WRITE_ENC = 3'd3;
    localparam logic [2:0] ST_ERR_ENC   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_READ  = ST_READ_ENC,
        ST_MERGE = ST_MERGE_ENC,
        ST_WRITE = ST_WRITE_ENC,
        ST_ERR   = ST_ERR_ENC
    } store_state_e;

    // A store is rejected when funct3 is not a store code, or when the
    // address is not naturally aligned for the access size.
    function automatic logic is_bad_store(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic bad;
        case (funct3)
            F3_SB:   bad = 1'b0;
            F3_SH:   bad = addr_lo[0];
            F3_SW:   bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage : store_pkg

// File: rtl/store_lane_merge.sv
// -----------------------------------------------------------------------------
// store_lane_merge
//   Combinational lane insertion for sub-word stores (little-endian).
//   Ports:
//     i_old_word [31:0]  word read back from memory
//     i_funct3   [2:0]   store type (sb / sh; anything else passes old word)
//     i_addr_lo  [1:0]   byte offset within the word
//     i_wdata    [15:0]  low halfword of rs2 (sb uses only [7:0])
//     o_merged   [31:0]  old word with the target lane(s) replaced
// -----------------------------------------------------------------------------
module store_lane_merge
    import store_pkg::*;
(
    input  logic [31:0] i_old_word,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_merged
);

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned and infers a latch.
    always_comb begin
        o_merged = i_old_word;
        case (i_funct3)
            F3_SB: begin
                case (i_addr_lo)
                    2'd0: o_merged[7:0]   = i_wdata[7:0];
                    2'd1: o_merged[15:8]  = i_wdata[7:0];
                    2'd2: o_merged[23:16] = i_wdata[7:0];
                    2'd3: o_merged[31:24] = i_wdata[7:0];
                    default: ;
                endcase
            end
            F3_SH: begin
                if (i_addr_lo[1]) begin
                    o_merged[31:16] = i_wdata;
                end else begin
                    o_merged[15:0]  = i_wdata;
                end
            end
            default: ;
        endcase
    end

endmodule : store_lane_merge

// File: rtl/store_rmw_unit.sv
// -----------------------------------------------------------------------------
// store_rmw_unit
//   Store path to a word-wide data memory without byte enables. Word stores
//   are written directly; byte/halfword stores read the word, merge the new
//   lane and write it back. Undefined or misaligned stores are rejected with
//   a done+err pulse and no memory access.
//   Ports:
//     clk, reset        clock; synchronous active-high reset
//     req_valid/ready   request handshake (ready only while idle)
//     req_funct3 [2:0]  store type (sb/sh/sw)
//     req_addr   [31:0] byte address
//     req_wdata  [31:0] rs2 value
//     done              one-cycle completion pulse
//     err               one-cycle reject pulse, coincident with done
//     mem_addr   [31:0] word-aligned address, 0 while idle
//     mem_re / mem_we   memory read / write strobes (never together)
//     mem_wdata  [31:0] word to write, 0 when mem_we is low
//     mem_rdata  [31:0] read data, valid the cycle after mem_re
// -----------------------------------------------------------------------------
module store_rmw_unit
    import store_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        done,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    store_state_e r_state;
    store_state_e w_state_next;

    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merged;

    logic        w_accept;
    logic [31:0] w_merged;

    assign w_accept = req_valid && (r_state == ST_IDLE);

    store_lane_merge u_lane_merge (
        .i_old_word (mem_rdata),
        .i_funct3   (r_funct3),
        .i_addr_lo  (r_addr[1:0]),
        .i_wdata    (r_wdata[15:0]),
        .o_merged   (w_merged)
    );

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (is_bad_store(req_funct3, req_addr[1:0])) begin
                        w_state_next = ST_ERR;
                    end else if (req_funct3 == F3_SW) begin
                        w_state_next = ST_WRITE;
                    end else begin
                        w_state_next = ST_READ;
                    end
                end
            end
            ST_READ:  w_state_next = ST_MERGE;
            ST_MERGE: w_state_next = ST_WRITE;
            ST_WRITE: w_state_next = ST_IDLE;
            ST_ERR:   w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: every register, including the request latches and the
            // merge register, is cleared so outputs are defined after reset.
            r_state  <= ST_IDLE;
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_merged <= 32'h0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end
            // mem_rdata is valid in MERGE because READ issued the strobe
            if (r_state == ST_MERGE) begin
                r_merged <= w_merged;
            end
        end
    end

    // Outputs decode directly from the registered state, so reset drives
    // them to their idle values in the following cycle.
    assign req_ready = (r_state == ST_IDLE);
    assign mem_re    = (r_state == ST_READ);
    assign mem_we    = (r_state == ST_WRITE);
    assign done      = (r_state == ST_WRITE) || (r_state == ST_ERR);
    assign err       = (r_state == ST_ERR);
    assign mem_addr  = (r_state == ST_IDLE) ? 32'h0 : {r_addr[31:2], 2'b00};

    // sw writes the latched rs2 word untouched; sub-word stores write the merge
    assign mem_wdata = (r_state != ST_WRITE) ? 32'h0 :
                       (r_funct3 == F3_SW)   ? r_wdata : r_merged;

endmodule : store_rmw_unit

// File: tb/tb_store_rmw_unit.sv
module tb_store_rmw_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        done;
    logic        err;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    // Bench memory (the device's target) and the reference image of it
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_val;

    store_rmw_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .done       (done),
        .err        (err),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_idx] <= pre_val;
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
        mem_rdata <= mem_re ? mem[mem_addr[7:2]] : 32'h0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        pre_we  = 1'b1;
        pre_idx = idx[5:0];
        pre_val = val;
        ref_mem[idx] = val;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Expected memory word after a store, from the byte-lane rules
    function automatic logic [31:0] model_word(input logic [31:0] old, input logic [2:0] f3,
                                               input logic [31:0] addr, input logic [31:0] wd);
        int sh;
        case (f3)
            3'b000: begin
                sh = int'(addr[1:0]) * 8;
                return (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
            end
            3'b001: begin
                sh = int'(addr[1]) * 16;
                return (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
            end
            3'b010:  return wd;
            default: return old;
        endcase
    endfunction

    function automatic logic model_bad(input logic [2:0] f3, input logic [31:0] addr);
        return !((f3 == 3'b000) ||
                 (f3 == 3'b001 && addr[0] == 1'b0) ||
                 (f3 == 3'b010 && addr[1:0] == 2'b00));
    endfunction

    // Issue one store from IDLE and check every cycle until IDLE again.
    // Entered and left at a falling edge.
    task automatic run_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        logic        bad;
        logic [31:0] waddr;
        logic [31:0] exp_word;
        int          idx;
        bad      = model_bad(f3, addr);
        waddr    = addr & ~32'd3;
        idx      = int'(waddr[7:2]);
        exp_word = model_word(ref_mem[idx], f3, addr, wd);

        check("ready_before", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge clk);
        // Scramble the request so only the latched copy can be correct
        req_valid  = 1'b0;
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;

        if (bad) begin
            check("err_done", {30'b0, done, err}, 32'd3);
            check("err_strobes", {30'b0, mem_re, mem_we}, 32'd0);
            check("err_ready", {31'b0, req_ready}, 32'd0);
        end else if (f3 == 3'b010) begin
            check("sw_strobes", {30'b0, mem_re, mem_we}, 32'd1);
            check("sw_done", {30'b0, done, err}, 32'd2);
            check("sw_addr", mem_addr, waddr);
            check("sw_wdata", mem_wdata, exp_word);
        end else begin
            check("rd_strobes", {30'b0, mem_re, mem_we}, 32'd2);
            check("rd_done_ready", {30'b0, done, req_ready}, 32'd0);
            check("rd_addr", mem_addr, waddr);
            check("rd_wdata_zero", mem_wdata, 32'd0);
            @(negedge clk);
            check("mg_strobes", {29'b0, mem_re, mem_we, done}, 32'd0);
            check("mg_ready", {31'b0, req_ready}, 32'd0);
            check("mg_addr", mem_addr, waddr);
            @(negedge clk);
            check("wr_strobes", {30'b0, mem_re, mem_we}, 32'd1);
            check("wr_done", {29'b0, done, err, req_ready}, 32'd4);
            check("wr_addr", mem_addr, waddr);
            check("wr_wdata", mem_wdata, exp_word);
        end
        if (!bad) ref_mem[idx] = exp_word;
        @(negedge clk);
        check("idle_ready", {31'b0, req_ready}, 32'd1);
        check("idle_quiet", {28'b0, mem_re, mem_we, done, err}, 32'd0);
        check("idle_addr", mem_addr, 32'd0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        int          r;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        pre_we     = 1'b0;
        pre_idx    = 6'd0;
        pre_val    = 32'h0;

        @(negedge clk);
        for (int i = 0; i < 64; i++) preload(i, $urandom);

        // Reset values
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_flags", {28'b0, mem_re, mem_we, done, err}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // sw aligned
        run_store(3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
        check("sw_mem", mem[4], 32'hDEAD_BEEF);

        // sb lane 2
        preload(8, 32'h1122_3344);
        run_store(3'b000, 32'h0000_0022, 32'hFFFF_FFAB);
        check("sb_mem", mem[8], 32'h11AB_3344);

        // sh upper half
        preload(3, 32'h1122_3344);
        run_store(3'b001, 32'h0000_000E, 32'h0000_CAFE);
        check("sh_mem", mem[3], 32'hCAFE_3344);

        // Misaligned and undefined
        run_store(3'b001, 32'h0000_0005, 32'h1234_5678);
        run_store(3'b010, 32'h0000_0002, 32'h1234_5678);
        run_store(3'b011, 32'h0000_0010, 32'h1234_5678);
        check("rej_mem", mem[4], 32'hDEAD_BEEF);

        // Busy: req_valid held high across an sb, second request waits
        preload(12, 32'h1122_3344);
        check("bb_ready0", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h0000_0031;
        req_wdata  = 32'h0000_005A;
        @(negedge clk);
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0034;
        req_wdata  = 32'h1234_5678;
        check("bb_ready1", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        check("bb_ready2", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        check("bb_ready3", {31'b0, req_ready}, 32'd0);
        check("bb_sb_we", {31'b0, mem_we}, 32'd1);
        check("bb_sb_wdata", mem_wdata, 32'h1122_5A44);
        @(negedge clk);
        check("bb_ready4", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("bb_sw_we", {29'b0, mem_we, done, err}, 32'd6);
        check("bb_sw_addr", mem_addr, 32'h0000_0034);
        check("bb_sw_wdata", mem_wdata, 32'h1234_5678);
        ref_mem[12] = 32'h1122_5A44;
        ref_mem[13] = 32'h1234_5678;
        @(negedge clk);
        check("bb_idle", {31'b0, req_ready}, 32'd1);

        // Reset during MERGE: the write must never happen
        req_valid  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h0000_0041;
        req_wdata  = 32'h0000_00EE;
        @(negedge clk);
        req_valid = 1'b0;
        check("ab_read", {31'b0, mem_re}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("ab_ready", {31'b0, req_ready}, 32'd1);
        check("ab_quiet", {28'b0, mem_re, mem_we, done, err}, 32'd0);
        check("ab_addr", mem_addr, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ab_quiet2", {28'b0, mem_re, mem_we, done, err}, 32'd0);

        // Randomized stores against the reference model
        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3)      f3 = 3'b000;
            else if (r < 6) f3 = 3'b001;
            else if (r < 8) f3 = 3'b010;
            else            f3 = 3'($urandom_range(3, 7));
            a = 32'($urandom_range(0, 255));
            run_store(f3, a, $urandom);
        end

        // Whole memory image against the model
        for (int i = 0; i < 64; i++) check($sformatf("mem_%0d", i), mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_store_rmw_unit

// File: doc/store_rmw_unit.md
# store_rmw_unit

Store-path companion to the load sign/zero-extend stage. It accepts a store request from the CPU (sb, sh or sw with address and rs2 data) and writes it to a word-wide data memory that has no byte enables. Sub-word stores use a read-modify-write sequence; word stores are a single write. Misaligned or undefined stores are rejected. The block sits between the execute/memory stage and the data memory port.

## Interface
- Parameters: none. Data and address are fixed at 32 bits.
- Ports:
  - clk  in  1  system clock; all state changes on the rising edge
  - reset  in  1  synchronous, active-high reset
  - req_valid  in  1  store request present
  - req_ready  out  1  block idle; a request is accepted when req_valid & req_ready
  - req_funct3  in  3  store type: 000 sb, 001 sh, 010 sw; any other value is undefined
  - req_addr  in  32  byte address
  - req_wdata  in  32  rs2 value; only the low byte or halfword is used for sb/sh
  - done  out  1  one-cycle pulse when the request completes
  - err  out  1  one-cycle pulse, coincident with done, for a rejected request
  - mem_addr  out  32  word-aligned memory address: {addr[31:2], 2'b00}
  - mem_re  out  1  memory read strobe
  - mem_we  out  1  memory write strobe
  - mem_wdata  out  32  full word to write
  - mem_rdata  in  32  memory read data, valid one cycle after mem_re

## Operation
- States: IDLE, READ, MERGE, WRITE, ERR.
- **IDLE**
  - req_ready=1. On acceptance, latch funct3, addr and wdata.
  - Next state is ERR if the request is bad: funct3 not in {000, 001, 010}, sh with addr[0]=1, or sw with addr[1:0]≠00.
  - Otherwise next state is WRITE for sw and READ for sb/sh.
- **READ**
  - mem_re=1 with mem_addr set to the latched word address.
  - Next state is MERGE.
- **MERGE**
  - Take mem_rdata and replace the target lane. Byte order is little-endian.
  - sb: byte lane addr[1:0] gets wdata[7:0].
  - sh: lanes {addr[1],0} and {addr[1],1} get wdata[15:0]; addr[1]=0 selects [15:0], addr[1]=1 selects [31:16].
  - The merged word is registered. Next state is WRITE.
- **WRITE**
  - mem_we=1 and mem_wdata = merged word (sb/sh) or latched wdata (sw).
  - done=1. Next state is IDLE.
- **ERR**
  - done=1 and err=1. No memory strobe. Next state is IDLE.
- mem_addr is held at the latched word address in every non-IDLE state and is 0 in IDLE.
- mem_re and mem_we are never asserted in the same cycle.
- mem_wdata is 0 whenever mem_we=0.

## Timing
- Reset values:
  - State is IDLE, so req_ready=1.
  - done, err, mem_re and mem_we are 0.
  - mem_addr and mem_wdata are 0.
  - Latched registers are 0.
- Latency, with acceptance in cycle T:
  - sb/sh: READ at T+1, MERGE at T+2, WRITE and done at T+3, next acceptance possible at T+4.
  - sw: WRITE and done at T+1, next acceptance at T+2.
  - Rejected request: done and err at T+1, no memory access.
- req_ready=0 in every non-IDLE state. req_valid is ignored while busy; the requester must hold its request until it is accepted.
- Reset asserted in any state: the block is in IDLE with all outputs at reset values in the cycle after reset is sampled. A write interrupted before WRITE is never issued. No done pulse is produced for an aborted request.
- No back-to-back acceptance in the same cycle as done. done occurs in the WRITE or ERR state, where req_ready=0.

## Structure
- Shared package (store_pkg):
  - funct3 constants F3_SB=3'b000, F3_SH=3'b001, F3_SW=3'b010. The load constants are added alongside them.
  - State encoding constants for the five states.
- Sub-module store_lane_merge (combinational): inputs old word, funct3, addr[1:0] and wdata; output merged word. It is instantiated once, in the MERGE path.
- The FSM, request latches and output registers live in store_rmw_unit.

## Test plan
- **sw aligned:** addr=0x0000_0010, wdata=0xDEADBEEF. Expect mem_we at T+1 with mem_addr=0x10 and mem_wdata=0xDEADBEEF, done at T+1, mem_re never asserted.
- **sb, lane 2:** memory holds 0x11223344, addr=0x22, wdata=0xFFFF_FFAB. Expect mem_re at T+1 with mem_addr=0x20, then mem_we at T+3 with mem_wdata=0x11AB3344, done at T+3.
- **sh, upper half:** memory holds 0x11223344, addr=0x0E, wdata=0x0000_CAFE. Expect a write of 0xCAFE3344 to address 0x0C.
- **Misaligned and undefined:** sh with addr=0x05, sw with addr=0x02, and funct3=3'b011. Each gives done=err=1 at T+1 with no mem_re or mem_we.
- **Busy / back-to-back:** hold req_valid high across an sb. Expect req_ready=0 for T+1..T+3 and the second request accepted at T+4.
- **Reset mid-operation:** assert reset in MERGE. Expect no mem_we, no done, and req_ready=1 one cycle after reset is sampled.
